// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: sizes, scheduler state encoding and the small-sigma mixing functions.
// The compression stage uses this package too.
package sha256_pkg;

    localparam int WORD_W      = 32;
    localparam int ROUNDS      = 64;
    localparam int BLOCK_WORDS = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } sched_state_e;

    // sigma0: ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sig0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    // sigma1: ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sig1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/w_expand.sv
// Combinational schedule expansion.
// Computes W_t from W_{t-2}, W_{t-7}, W_{t-15} and W_{t-16}; the sum wraps modulo 2^32.
module w_expand
    import sha256_pkg::*;
(
    input  logic [31:0] w_m2_i,
    input  logic [31:0] w_m7_i,
    input  logic [31:0] w_m15_i,
    input  logic [31:0] w_m16_i,
    output logic [31:0] w_o
);

    assign w_o = sig1(w_m2_i) + w_m7_i + sig0(w_m15_i) + w_m16_i;

endmodule

// File: rtl/message_scheduler.sv
// SHA-256 message scheduler.
// Loads 16 message words, then emits W0..W63 one per cycle to the compression stage.
module message_scheduler #(
    parameter int WORD_W      = sha256_pkg::WORD_W,
    parameter int ROUNDS      = sha256_pkg::ROUNDS,
    parameter int BLOCK_WORDS = sha256_pkg::BLOCK_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              load_ready,
    input  logic              hold,
    output logic [WORD_W-1:0] w_out,
    output logic [5:0]        round_n,
    output logic              w_valid,
    output logic              busy,
    output logic              done
);
    import sha256_pkg::*;

    localparam logic [5:0] LAST_K = 6'(BLOCK_WORDS - 1);
    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    sched_state_e state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [5:0]   rnd_q, rnd_d;
    logic         vld_q, vld_d;
    logic [WORD_W-1:0] w_out_q, w_out_d;
    logic [WORD_W-1:0] w_next;

    // Element 0 is the oldest word (W_{t-16}); element 15 is the newest (W_{t-1}).
    logic [BLOCK_WORDS-1:0][WORD_W-1:0] win_q, win_d;

    w_expand u_w_expand (
        .w_m2_i  (win_q[14]),
        .w_m7_i  (win_q[9]),
        .w_m15_i (win_q[1]),
        .w_m16_i (win_q[0]),
        .w_o     (w_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rnd_q   <= '0;
            vld_q   <= 1'b0;
            w_out_q <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            vld_q   <= vld_d;
            w_out_q <= w_out_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rnd_d   = rnd_q;
        vld_d   = 1'b0;
        w_out_d = w_out_q;
        win_d   = win_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    win_d   = {in_word, win_q[BLOCK_WORDS-1:1]};
                    w_out_d = in_word;
                    rnd_d   = cnt_q;
                    vld_d   = 1'b1;
                    cnt_d   = cnt_q + 6'd1;
                    // Word 15 leaves the counter at 16, which is the first generated round.
                    if (cnt_q == LAST_K) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!hold) begin
                    win_d   = {w_next, win_q[BLOCK_WORDS-1:1]};
                    w_out_d = w_next;
                    rnd_d   = cnt_q;
                    vld_d   = 1'b1;
                    cnt_d   = cnt_q + 6'd1;
                    if (cnt_q == LAST_T) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign w_out      = w_out_q;
    assign round_n    = rnd_q;
    assign w_valid    = vld_q;
    assign load_ready = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_message_scheduler.sv
// Directed bench for message_scheduler, covering abc/zero/mixed blocks, hold, gapped load,
// ignored start pulses and mid-run reset, against a reference schedule model.
module tb_message_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        hold = 1'b0;
    logic [31:0] in_word = '0;
    logic        load_ready, w_valid, busy, done;
    logic [31:0] w_out;
    logic [5:0]  round_n;

    int total = 0;
    int bad = 0;

    logic [5:0]  rq[$];
    logic [31:0] wq[$];
    int          ndone = 0;
    logic [31:0] model[64];
    logic [31:0] abc[16];
    logic [31:0] zer[16];
    logic [31:0] mix[16];

    message_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .load_ready (load_ready),
        .hold       (hold),
        .w_out      (w_out),
        .round_n    (round_n),
        .w_valid    (w_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (w_valid) begin
                rq.push_back(round_n);
                wq.push_back(w_out);
            end
            if (done) ndone++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_model(input logic [31:0] blk[16]);
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) model[i] = blk[i];
        for (int i = 16; i < 64; i++) begin
            a = ror(model[i-15], 7) ^ ror(model[i-15], 18) ^ (model[i-15] >> 3);
            b = ror(model[i-2], 17) ^ ror(model[i-2], 19) ^ (model[i-2] >> 10);
            model[i] = b + model[i-7] + a + model[i-16];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input string nm, input logic [31:0] blk[16], input int gap,
                             input int hold_len, input bit noise, input bit iv_at_start);
        bit seen;
        build_model(blk);
        rq.delete();
        wq.delete();
        ndone = 0;

        // Start cycle; optionally with a competing in_valid that must not be consumed.
        in_valid = iv_at_start;
        in_word  = 32'hDEADBEEF;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk({nm, "_load_ready"}, 32'(load_ready), 32'd1);
        chk({nm, "_busy_load"}, 32'(busy), 32'd1);
        chk({nm, "_no_consume"}, 32'(w_valid), 32'd0);

        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_word  = blk[k];
            start    = noise && (k == 5);
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            repeat (gap) tick();
            if (gap > 0 && k == 0) chk({nm, "_gap_novalid"}, 32'(w_valid), 32'd0);
        end
        chk({nm, "_run_ready"}, 32'(load_ready), 32'd0);

        // Generate W16..W29.
        for (int e = 0; e < 14; e++) begin
            start = noise && (e == 3);
            tick();
            start = 1'b0;
        end

        if (hold_len > 0) begin
            hold = 1'b1;
            for (int h = 0; h < hold_len; h++) begin
                tick();
                chk({nm, "_hold_novalid"}, 32'(w_valid), 32'd0);
                chk({nm, "_hold_round"}, 32'(round_n), 32'd29);
            end
            hold = 1'b0;
            tick();
            chk({nm, "_resume_valid"}, 32'(w_valid), 32'd1);
            chk({nm, "_resume_round"}, 32'(round_n), 32'd30);
            chk({nm, "_resume_word"}, w_out, model[30]);
        end

        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({nm, "_done_busy"}, 32'(busy), 32'd0);
            chk({nm, "_done_valid"}, 32'(w_valid), 32'd1);
            chk({nm, "_done_round"}, 32'(round_n), 32'd63);
            chk({nm, "_done_word"}, w_out, model[63]);
            tick();
            chk({nm, "_idle_done"}, 32'(done), 32'd0);
            chk({nm, "_idle_valid"}, 32'(w_valid), 32'd0);
            chk({nm, "_idle_round"}, 32'(round_n), 32'd63);
            chk({nm, "_idle_word"}, w_out, model[63]);
        end

        chk({nm, "_nvalid"}, 32'(rq.size()), 32'd64);
        chk({nm, "_ndone"}, 32'(ndone), 32'd1);
        for (int i = 0; i < 64 && i < rq.size(); i++) begin
            chk($sformatf("%s_round%0d", nm, i), 32'(rq[i]), 32'(i));
            chk($sformatf("%s_w%0d", nm, i), wq[i], model[i]);
        end
    endtask

    task automatic chk_abc_consts(input string nm);
        chk({nm, "_cnt_ge20"}, 32'(wq.size() >= 20), 32'd1);
        if (wq.size() >= 20) begin
            chk({nm, "_W16"}, wq[16], 32'h61626380);
            chk({nm, "_W17"}, wq[17], 32'h000F0000);
            chk({nm, "_W18"}, wq[18], 32'h7DA86405);
            chk({nm, "_W19"}, wq[19], 32'h600003C6);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            abc[i] = 32'h0;
            zer[i] = 32'h0;
            mix[i] = 32'h01234567 + 32'(i) * 32'h9E3779B9;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        #12;
        chk("rst_w_out", w_out, 32'h0);
        chk("rst_round", 32'(round_n), 32'd0);
        chk("rst_valid", 32'(w_valid), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        run_block("abc", abc, 0, 0, 1'b0, 1'b1);
        chk_abc_consts("abc");
        run_block("zero", zer, 0, 0, 1'b0, 1'b0);
        run_block("hold", abc, 0, 5, 1'b0, 1'b0);
        run_block("gap", mix, 3, 0, 1'b0, 1'b0);
        run_block("noise", mix, 0, 0, 1'b1, 1'b0);

        // Mid-run reset at t=40: the partial block is abandoned.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1;
            in_word  = mix[k];
            tick();
        end
        in_valid = 1'b0;
        repeat (25) tick();
        chk("mid_round40", 32'(round_n), 32'd40);
        #2 rst = 1'b1;
        #1;
        chk("arst_w_out", w_out, 32'h0);
        chk("arst_round", 32'(round_n), 32'd0);
        chk("arst_valid", 32'(w_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(load_ready), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        tick();
        #3 rst = 1'b0;
        tick();

        run_block("post_rst", abc, 0, 0, 1'b0, 1'b0);
        chk_abc_consts("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
